// File: rtl/jar_sram_driver.sv
// Host-side pin sequencer for the 8-byte shared-pin SRAM: expands byte read/write requests into SRAM steps.
// Optional 8-byte streaming burst read is enabled by defining JAR_SRAM_DRIVER_BURST_EN.
module jar_sram_driver #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic          req_burst,
    input  logic [2:0]    req_addr,
    input  logic [DW-1:0] req_data,
    output logic          resp_valid,
    output logic [DW-1:0] resp_data,
    output logic [7:0]    sram_io_in,
    input  logic [7:0]    sram_io_out
);

`ifdef JAR_SRAM_DRIVER_BURST_EN
    typedef enum logic [3:0] {
        IDLE, W0_L, W0_H, W1_L, W1_H, CM_L, CM_H, RD_L, RD_H, RD_C,
        BS_L, BS_H, ST_L, ST_H, DRAIN
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, W0_L, W0_H, W1_L, W1_H, CM_L, CM_H, RD_L, RD_H, RD_C
    } state_t;
`endif

    state_t        state, state_next;
    logic [2:0]    addr_q, addr_n;
    logic [DW-1:0] data_q, data_n;
    logic          accept;
    logic          cap;
    logic [2:0]    ctrl;
    logic [AW-1:0] nib;
    logic          sclk;
    logic [7:0]    io_d;

`ifdef JAR_SRAM_DRIVER_BURST_EN
    logic [2:0]    cnt;
    logic          cnt_inc;
`else
    logic          unused_burst;
    assign unused_burst = req_burst;
`endif

    assign req_ready = (state == IDLE);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cap        = 1'b0;
`ifdef JAR_SRAM_DRIVER_BURST_EN
        cnt_inc    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_write) begin
                        state_next = W0_L;
                    end else begin
`ifdef JAR_SRAM_DRIVER_BURST_EN
                        state_next = req_burst ? BS_L : RD_L;
`else
                        state_next = RD_L;
`endif
                    end
                end
            end
            W0_L: state_next = W0_H;
            W0_H: state_next = W1_L;
            W1_L: state_next = W1_H;
            W1_H: state_next = CM_L;
            CM_L: state_next = CM_H;
            CM_H: state_next = IDLE;
            RD_L: state_next = RD_H;
            RD_H: state_next = RD_C;
            RD_C: begin
                cap        = 1'b1;
                state_next = IDLE;
            end
`ifdef JAR_SRAM_DRIVER_BURST_EN
            BS_L: state_next = BS_H;
            BS_H: state_next = ST_L;
            ST_L: begin
                // the first stream step has nothing to capture yet
                cap        = (cnt != 3'd0);
                state_next = ST_H;
            end
            ST_H: begin
                if (cnt == 3'd7) begin
                    state_next = DRAIN;
                end else begin
                    cnt_inc    = 1'b1;
                    state_next = ST_L;
                end
            end
            DRAIN: begin
                cap        = 1'b1;
                state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Pins are registered from the next state so the SRAM clock bit is glitch-free
    // and controls are already stable in the L cycle before bit0 rises.
    always_comb begin
        addr_n = accept ? req_addr : addr_q;
        data_n = accept ? req_data : data_q;
        ctrl   = 3'b000;
        nib    = '0;
        sclk   = 1'b0;
        case (state_next)
            W0_L, W0_H: begin
                ctrl = 3'b001;
                nib  = data_n[AW-1:0];
            end
            W1_L, W1_H: begin
                ctrl = 3'b001;
                nib  = data_n[DW-1:AW];
            end
            CM_L, CM_H: begin
                ctrl = 3'b100;
                nib  = AW'(addr_n);
            end
            RD_L, RD_H, RD_C: begin
                ctrl = 3'b010;
                nib  = AW'(addr_n);
            end
`ifdef JAR_SRAM_DRIVER_BURST_EN
            BS_L, BS_H: begin
                ctrl = 3'b111;
                nib  = AW'(addr_n);
            end
            ST_L, ST_H: begin
                ctrl = 3'b011;
                nib  = AW'(addr_n);
            end
            DRAIN: begin
                ctrl = 3'b010;
                nib  = AW'(addr_n);
            end
`endif
            default: ;
        endcase
        case (state_next)
`ifdef JAR_SRAM_DRIVER_BURST_EN
            W0_H, W1_H, CM_H, RD_H, BS_H, ST_H: sclk = 1'b1;
`else
            W0_H, W1_H, CM_H, RD_H: sclk = 1'b1;
`endif
            default: sclk = 1'b0;
        endcase
        io_d = {nib, ctrl, sclk};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            sram_io_in <= 8'h00;
`ifdef JAR_SRAM_DRIVER_BURST_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_next;
            sram_io_in <= io_d;
            resp_valid <= cap;
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_data;
            end
            if (cap) begin
                resp_data <= sram_io_out[DW-1:0];
            end
`ifdef JAR_SRAM_DRIVER_BURST_EN
            if (accept) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 3'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_jar_sram_driver.sv
// Self-checking bench for jar_sram_driver: table vectors, corner sequences and randomized ops
// against a memory-level reference, with a behavioural model of the shared-pin SRAM attached.
module tb_jar_sram_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic       req_burst;
    logic [2:0] req_addr;
    logic [7:0] req_data;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic [7:0] sram_io_in;
    logic [7:0] sram_io_out;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ref_mem [8];

    always #5 clk = ~clk;

    jar_sram_driver dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_burst  (req_burst),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .sram_io_in (sram_io_in),
        .sram_io_out(sram_io_out)
    );

    // SRAM pin protocol model: acts on the rising edge of its own clock bit.
    logic [7:0] s_mem [8] = '{default: 8'h00};
    logic [7:0] s_sr  = 8'h00;
    logic [7:0] s_out = 8'h00;
    logic [2:0] s_idx = 3'd0;
    assign sram_io_out = s_out;

    always @(posedge sram_io_in[0]) begin
        if (sram_io_in[1] && sram_io_in[2] && sram_io_in[3]) begin
            s_idx <= sram_io_in[6:4];
        end else if (sram_io_in[1] && sram_io_in[2]) begin
            s_out <= s_mem[s_idx];
            s_idx <= s_idx + 3'd1;
        end else if (sram_io_in[3]) begin
            s_mem[sram_io_in[6:4]] <= s_sr;
        end else if (sram_io_in[1]) begin
            s_sr <= {sram_io_in[7:4], s_sr[7:4]};
        end else if (sram_io_in[2]) begin
            s_out <= s_mem[sram_io_in[6:4]];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // pin image: {nibble, commit, oe, we, clk}
    function automatic logic [7:0] pin(input logic [2:0] ctl, input logic [3:0] n, input logic ck);
        return {n, ctl, ck};
    endfunction

    task automatic write_op(input logic [2:0] a, input logic [7:0] d, input bit poke);
        logic [7:0] exp [6];
        exp[0] = pin(3'b001, d[3:0], 1'b0);
        exp[1] = pin(3'b001, d[3:0], 1'b1);
        exp[2] = pin(3'b001, d[7:4], 1'b0);
        exp[3] = pin(3'b001, d[7:4], 1'b1);
        exp[4] = pin(3'b100, {1'b0, a}, 1'b0);
        exp[5] = pin(3'b100, {1'b0, a}, 1'b1);
        @(posedge clk); #1;
        req_write = 1'b1; req_burst = 1'b0; req_addr = a; req_data = d; req_valid = 1'b1;
        @(negedge clk);
        chk("wr_ready_accept", req_ready, 1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (poke && k < 6) begin
                req_write = 1'(($urandom_range(0, 1)));
                req_addr  = 3'($urandom_range(0, 7));
                req_data  = 8'($urandom_range(0, 255));
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("wr_pins_T%0d", k), sram_io_in, exp[k-1]);
            chk("wr_ready_busy", req_ready, 0);
            chk("wr_no_resp", resp_valid, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_pins_idle", sram_io_in, 8'h00);
        chk("wr_ready_done", req_ready, 1);
        chk("wr_no_resp_done", resp_valid, 0);
        ref_mem[a] = d;
    endtask

    // pre: request already presented by the previous read's last cycle
    task automatic read_op(input logic [2:0] a, input logic [7:0] e, input logic burst,
                           input bit pre, input bit chain, input logic [2:0] chain_addr);
        if (!pre) begin
            @(posedge clk); #1;
            req_write = 1'b0; req_burst = burst; req_addr = a; req_valid = 1'b1;
            @(negedge clk);
            chk("rd_ready_accept", req_ready, 1);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            req_addr  = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk($sformatf("rd_pins_T%0d", k), sram_io_in, pin(3'b010, {1'b0, a}, (k == 2)));
            chk("rd_ready_busy", req_ready, 0);
            chk("rd_no_resp_early", resp_valid, 0);
        end
        @(posedge clk); #1;
        if (chain) begin
            req_write = 1'b0; req_burst = 1'b0; req_addr = chain_addr; req_valid = 1'b1;
        end
        @(negedge clk);
        chk("rd_resp_valid", resp_valid, 1);
        chk($sformatf("rd_data_a%0d", a), resp_data, e);
        chk("rd_ready_T4", req_ready, 1);
        chk("rd_pins_idle", sram_io_in, 8'h00);
    endtask

`ifdef JAR_SRAM_DRIVER_BURST_EN
    task automatic burst_op(input logic [2:0] a);
        logic [2:0] ix;
        @(posedge clk); #1;
        req_write = 1'b0; req_burst = 1'b1; req_addr = a; req_valid = 1'b1;
        @(negedge clk);
        chk("bs_ready_accept", req_ready, 1);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            if (c == 1) chk("bs_pins_L", sram_io_in, pin(3'b111, {1'b0, a}, 1'b0));
            if (c == 2) chk("bs_pins_H", sram_io_in, pin(3'b111, {1'b0, a}, 1'b1));
            if (c >= 6 && (c % 2) == 0) begin
                ix = a + 3'((c - 6) / 2);
                chk($sformatf("bs_valid_T%0d", c), resp_valid, 1);
                chk($sformatf("bs_data_T%0d", c), resp_data, ref_mem[ix]);
            end else begin
                chk($sformatf("bs_quiet_T%0d", c), resp_valid, 0);
            end
            chk($sformatf("bs_ready_T%0d", c), req_ready, (c == 20));
        end
        req_burst = 1'b0;
    endtask
`endif

    typedef struct {
        bit         wr;
        logic [2:0] a;
        logic [7:0] d;   // write data, or expected read data
    } vec_t;

    vec_t tbl [14];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_burst = 1'b0;
        req_addr = 3'd0; req_data = 8'h00;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;

        tbl[0]  = '{1'b1, 3'd0, 8'h11};
        tbl[1]  = '{1'b1, 3'd1, 8'h22};
        tbl[2]  = '{1'b1, 3'd2, 8'h33};
        tbl[3]  = '{1'b1, 3'd3, 8'h44};
        tbl[4]  = '{1'b1, 3'd4, 8'h55};
        tbl[5]  = '{1'b1, 3'd5, 8'h66};
        tbl[6]  = '{1'b1, 3'd6, 8'h77};
        tbl[7]  = '{1'b1, 3'd7, 8'h88};
        tbl[8]  = '{1'b0, 3'd3, 8'h44};
        tbl[9]  = '{1'b0, 3'd7, 8'h88};
        tbl[10] = '{1'b0, 3'd0, 8'h11};
        tbl[11] = '{1'b1, 3'd3, 8'hA5};
        tbl[12] = '{1'b0, 3'd3, 8'hA5};
        tbl[13] = '{1'b0, 3'd5, 8'h66};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", req_ready, 1);
        chk("reset_pins", sram_io_in, 8'h00);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_data", resp_data, 8'h00);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) write_op(tbl[i].a, tbl[i].d, 1'b0);
            else           read_op(tbl[i].a, tbl[i].d, 1'b0, 1'b0, 1'b0, 3'd0);
        end
        write_op(3'd3, 8'h44, 1'b0);

        // busy write with competing requests held on the bus
        write_op(3'd4, 8'hC3, 1'b1);
        read_op(3'd4, 8'hC3, 1'b0, 1'b0, 1'b0, 3'd0);
        write_op(3'd4, 8'h55, 1'b0);

        // back-to-back reads, accepted at T+4
        read_op(3'd7, 8'h88, 1'b0, 1'b0, 1'b1, 3'd0);
        read_op(3'd0, 8'h11, 1'b0, 1'b1, 1'b0, 3'd0);

`ifdef JAR_SRAM_DRIVER_BURST_EN
        burst_op(3'd6);
`else
        read_op(3'd6, 8'h77, 1'b1, 1'b0, 1'b0, 3'd0);
        req_burst = 1'b0;
`endif

        // reset during W1_H of a write of 0xFF to addr 2
        write_op(3'd2, 8'h3C, 1'b0);
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 3'd2; req_data = 8'hFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid_W1_H", sram_io_in, 8'hF3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_pins", sram_io_in, 8'h00);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_resp_data", resp_data, 8'h00);
        read_op(3'd2, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0);

        // randomized traffic against the memory reference
        for (int n = 0; n < 150; n++) begin
            logic [2:0] a;
            logic [2:0] b;
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: write_op(a, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
                1: write_op(a, 8'($urandom_range(0, 255)), 1'b0);
                2: begin
                    read_op(a, ref_mem[a], 1'b0, 1'b0, 1'b1, b);
                    read_op(b, ref_mem[b], 1'b0, 1'b1, 1'b0, 3'd0);
                end
                default: begin
`ifdef JAR_SRAM_DRIVER_BURST_EN
                    read_op(a, ref_mem[a], 1'b0, 1'b0, 1'b0, 3'd0);
`else
                    read_op(a, ref_mem[a], 1'($urandom_range(0, 1)), 1'b0, 1'b0, 3'd0);
                    req_burst = 1'b0;
`endif
                end
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jar_sram_driver.md
# jar_sram_driver

Host-side sequencer that sits directly upstream of the 8-byte shared-pin SRAM (`jar_sram_top`-style pin protocol) and drives its 8-bit `io_in` bus. It accepts byte-wide read and write requests over a valid/ready handshake and expands each into the SRAM's pin-level step sequence, including the SRAM's own clock bit. It captures read data from the SRAM's `io_out` bus and returns it on a response strobe. An optional burst-read mode uses the SRAM's streaming access.

## Interface
- `AW`, 4, SRAM address/data nibble width.
- `DW`, 8, data width.
- `clk` input 1: block clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE.
- `req_write` input 1: 1 = write, 0 = read.
- `req_burst` input 1: burst read. Ignored unless the macro is defined.
- `req_addr` input 3: byte address.
- `req_data` input 8: write data.
- `resp_valid` output 1: one-cycle pulse per returned byte.
- `resp_data` output 8: read byte. Holds its value until the next capture.
- `sram_io_in` output 8: SRAM pins.
  - [0] SRAM clk, [1] we, [2] oe, [3] commit, [7:4] addr_data.
- `sram_io_out` input 8: SRAM data output.

## Operation
- A request is accepted on a cycle with `req_valid & req_ready`.
- IDLE drives `sram_io_in = 8'h00`.
- **SRAM step.** Each SRAM step is two cycles:
  - L phase: controls and nibble set, bit0 = 0.
  - H phase: same controls, bit0 = 1. The SRAM samples on this rising edge.
  - Controls never change in the same cycle that bit0 rises.
- **Write** (states W0_L, W0_H, W1_L, W1_H, CM_L, CM_H, then IDLE):
  - Step 1: we = 1, nibble = `req_data[3:0]`.
  - Step 2: we = 1, nibble = `req_data[7:4]`.
  - Step 3: commit = 1, nibble = `{1'b0, req_addr}`.
- **Read** (states RD_L, RD_H, RD_C, then IDLE):
  - RD_L / RD_H: oe = 1, nibble = `{1'b0, addr}`.
  - RD_C: oe = 1, bit0 = 0. `sram_io_out` is registered into `resp_data`, and `resp_valid` pulses the following cycle.
- Request fields (addr, data, write, burst) are latched at acceptance. Later input changes have no effect.
- `resp_data` resets to 8'h00.
- `resp_valid`, `req_ready` and `sram_io_in` reset to 0, 1 and 8'h00 respectively (`req_ready` is 1 in IDLE after reset).

## Timing
- Accept at cycle T.
- Write: `sram_io_in` sequence on T+1..T+6; `req_ready` high again at T+7. No response.
- Read: RD_L at T+1, RD_H at T+2, RD_C at T+3; `resp_valid` at T+4. `req_ready` is high at T+4, so a back-to-back accept is legal there.
- `req_valid` while busy is ignored; the request is not queued.
- `reset` during any state:
  - next cycle: IDLE, `sram_io_in = 0`, `resp_valid = 0`.
  - An uncommitted write never reaches SRAM memory. Its partial nibble is left in the SRAM shift register (the SRAM has no reset).
- Addresses are 3 bits; the nibble MSB is always 0.

## Configuration
- `JAR_SRAM_DRIVER_BURST_EN` defined: a read with `req_burst = 1` performs an 8-byte streaming read.
  - BS_L / BS_H: we = oe = commit = 1, nibble = `{0, addr}`. This loads the stream index.
  - Then 8 × (ST_L / ST_H) with we = oe = 1.
  - Each ST_L after the first captures the previous byte.
  - The final DRAIN state (oe = 1, bit0 = 0) captures byte 7.
  - Byte k = mem[(addr + k) mod 8]. It is captured at T+5+2k, with `resp_valid` at T+6+2k for k = 0..7.
  - IDLE at T+20.
- Undefined: the burst states are absent, and `req_burst` is ignored (a burst read becomes a single read).

## Test plan
- **Write then read.** Write 0xA5 to addr 3.
  - `sram_io_in` = 0x52, 0x53, 0xA2, 0xA3, 0x38, 0x39, then 0x00.
  - Then read addr 3: 0x34, 0x35, 0x34; `resp_data = 0xA5` with `resp_valid` at T+4.
- **Busy and hold.** During a write, assert `req_valid` with other data. The request is ignored, `req_ready = 0` through T+6, and the write fields hold.
- **Back-to-back reads.** Write 0x11..0x88 to addrs 0..7. Read addrs 7 and 0 back-to-back: responses are 0x88, then 0x11, four cycles apart.
- **Reset mid-write.** Assert `reset` in state W1_H of a write of 0xFF to addr 2 (prior contents 0x3C). Next cycle `sram_io_in = 0`; a read of addr 2 returns 0x3C.
- **Burst with wrap** (macro on). With the pattern above, burst from addr 6: eight pulses, two cycles apart, carrying 0x77, 0x88, 0x11, …, 0x66.
- **Burst with macro off.** The same burst request returns a single 0x77 at T+4.
